// File: rtl/aucohl_fifo_th.sv
// Synchronous first-word-fall-through FIFO with programmable almost-full/empty thresholds, sticky errors and a high-water mark.
// Zero read latency; a write is visible on rdata the cycle after its edge; a write to a full FIFO is accepted only alongside a read.
module aucohl_fifo_th #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   afull_th,
  input  logic [AW:0]   aempty_th,
  output logic          afull,
  output logic          aempty,
  input  logic          clr_err,
  output logic          overflow,
  output logic          underflow,
  output logic [AW:0]   max_level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level_q, level_nxt, max_q;
  logic          ovf_q, udf_q;
  logic          wr_ok, rd_ok, ovf_set, udf_set;

  assign empty  = (level_q == '0);
  assign full   = (level_q == DEPTH_L);
  assign level  = level_q;
  // Plain compares already give the threshold corner cases (0, >DEPTH, >=DEPTH).
  assign afull  = (level_q >= afull_th);
  assign aempty = (level_q <= aempty_th);
  assign rdata  = mem[rptr];

  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign max_level = max_q;

  assign wr_ok   = wr & (~full | rd);
  assign rd_ok   = rd & ~empty;
  assign ovf_set = ~flush & wr & full & ~rd;
  assign udf_set = ~flush & rd & empty;

  always_comb begin
    level_nxt = level_q;
    if (flush)
      level_nxt = '0;
    else if (wr_ok && !rd_ok)
      level_nxt = level_q + 1'b1;
    else if (rd_ok && !wr_ok)
      level_nxt = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      max_q   <= '0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        if (rd_ok) rptr <= rptr + 1'b1;
      end
      level_q <= level_nxt;
      // A new error in the same cycle as clr_err wins over the clear.
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      udf_q   <= udf_set | (udf_q & ~clr_err);
      if (clr_err)
        max_q <= level_nxt;
      else if (level_nxt > max_q)
        max_q <= level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush)
      mem[wptr] <= wdata;
  end

endmodule

// File: tb/tb_aucohl_fifo_th.sv
// Directed bench for aucohl_fifo_th: hand-computed expectations checked with immediate assertions.
module tb_aucohl_fifo_th;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr, rd, clr_err;
  logic [7:0] wdata, rdata;
  logic       empty, full, afull, aempty, overflow, underflow;
  logic [4:0] level, afull_th, aempty_th, max_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aucohl_fifo_th #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .wdata(wdata),
    .rd(rd), .rdata(rdata), .empty(empty), .full(full), .level(level),
    .afull_th(afull_th), .aempty_th(aempty_th), .afull(afull), .aempty(aempty),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow),
    .max_level(max_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    wdata = 8'h00; afull_th = 5'd16; aempty_th = 5'd3;
    step();
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_max", 32'(max_level), 32'd0);
    afull_th = 5'd0; #1;
    chk("afull_th0", 32'(afull), 32'd1);
    afull_th = 5'd16;
    rst_n = 1'b1;
    step();

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; wdata = 8'(i);
      step();
    end
    wr = 1'b0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_max", 32'(max_level), 32'd16);
    chk("fill_afull16", 32'(afull), 32'd1);
    chk("fill_ovf", 32'(overflow), 32'd0);
    afull_th = 5'd17; #1;
    chk("afull_th17", 32'(afull), 32'd0);
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rdata), 32'(i));
      step();
    end
    rd = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_max", 32'(max_level), 32'd16);
    chk("drain_udf", 32'(underflow), 32'd0);

    // Thresholds: aempty drops when level hits 4, afull rises when level hits 12
    afull_th = 5'd12; aempty_th = 5'd3;
    for (int k = 1; k <= 13; k++) begin
      wr = 1'b1; wdata = 8'(k - 1);
      step();
      chk("th_level", 32'(level), 32'(k));
      chk("th_aempty", 32'(aempty), (k <= 3) ? 32'd1 : 32'd0);
      chk("th_afull", 32'(afull), (k >= 12) ? 32'd1 : 32'd0);
    end
    wr = 1'b0;
    afull_th = 5'd14; #1;
    chk("th_afull14", 32'(afull), 32'd0);
    aempty_th = 5'd16; #1;
    chk("th_aempty16", 32'(aempty), 32'd1);
    aempty_th = 5'd3; #1;
    chk("th_aempty3", 32'(aempty), 32'd0);

    // Full pass-through: queue is 0..15, then rd&wr 0xAA
    for (int i = 13; i < 16; i++) begin
      wr = 1'b1; wdata = 8'(i);
      step();
    end
    chk("pt_full", 32'(full), 32'd1);
    rd = 1'b1; wr = 1'b1; wdata = 8'hAA;
    step();
    rd = 1'b0; wr = 1'b0;
    chk("pt_level", 32'(level), 32'd16);
    chk("pt_ovf", 32'(overflow), 32'd0);
    chk("pt_head", 32'(rdata), 32'h01);
    rd = 1'b1;
    for (int i = 0; i < 15; i++) step();
    rd = 1'b0;
    chk("pt_tail", 32'(rdata), 32'hAA);
    chk("pt_level1", 32'(level), 32'd1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("pt_empty", 32'(empty), 32'd1);

    // Overflow at full, underflow at empty, clear priority
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; wdata = 8'(8'h10 + i);
      step();
    end
    wdata = 8'hEE;
    step();
    wr = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_head", 32'(rdata), 32'h10);
    rd = 1'b1;
    for (int i = 0; i < 15; i++) step();
    rd = 1'b0;
    chk("ovf_last", 32'(rdata), 32'h1F);
    rd = 1'b1;
    step();
    chk("ovf_drained", 32'(empty), 32'd1);
    chk("udf_pre", 32'(underflow), 32'd0);
    step();
    rd = 1'b0;
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_level", 32'(level), 32'd0);
    clr_err = 1'b1; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("clr_udf_wins", 32'(underflow), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    step();
    clr_err = 1'b0;
    chk("clr_udf", 32'(underflow), 32'd0);
    chk("clr_max", 32'(max_level), 32'd0);

    // Simultaneous rd&wr on empty
    rd = 1'b1; wr = 1'b1; wdata = 8'h55;
    step();
    rd = 1'b0; wr = 1'b0;
    chk("emp_level", 32'(level), 32'd1);
    chk("emp_udf", 32'(underflow), 32'd1);
    chk("emp_data", 32'(rdata), 32'h55);
    chk("emp_max", 32'(max_level), 32'd1);

    // Flush at level 7 with a write pending
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; wdata = 8'(8'h60 + i);
      step();
    end
    chk("fl_pre", 32'(level), 32'd7);
    flush = 1'b1; wr = 1'b1; wdata = 8'h77;
    step();
    flush = 1'b0; wr = 1'b0;
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_max", 32'(max_level), 32'd7);
    chk("fl_udf", 32'(underflow), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd0);

    // Async reset between edges
    wr = 1'b1; wdata = 8'h99;
    step();
    step();
    wr = 1'b0;
    chk("ar_pre", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_udf", 32'(underflow), 32'd0);
    chk("ar_max", 32'(max_level), 32'd0);
    chk("ar_aempty", 32'(aempty), 32'd1);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
